// File: rtl/multiword_addsub_seq.sv
// Multi-word add/subtract sequencer: runs one WIDTH-bit add/sub slice per cycle,
// least-significant slice first, and chains the carry between slices in a register.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   start               request an operation; sampled only while busy=0
//   control_signal      0 = add, 1 = subtract (data_in1 - data_in2)
//   data_in1, data_in2  operands; captured on the accepting edge
//   busy                high while slices are being processed
//   done                one-cycle pulse when the result is complete
//   data_out            result, written slice by slice during RUN
//   carry_out           final carry of an add (0 for subtract)
//   borrow_out          final borrow of a subtract (0 for add)
//   overflow            signed overflow of the full-width operation
module multiword_addsub_seq #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned WORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     control_signal,
   input  logic [WIDTH*WORDS-1:0]   data_in1,
   input  logic [WIDTH*WORDS-1:0]   data_in2,
   output logic                     busy,
   output logic                     done,
   output logic [WIDTH*WORDS-1:0]   data_out,
   output logic                     carry_out,
   output logic                     borrow_out,
   output logic                     overflow
);

   localparam int unsigned DW    = WIDTH * WORDS;
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [DW-1:0]      a_q, a_d;
   logic [DW-1:0]      b_q, b_d;
   logic               op_q, op_d;
   logic [DW-1:0]      data_out_q, data_out_d;
   logic               carry_out_q, carry_out_d;
   logic               borrow_out_q, borrow_out_d;
   logic               overflow_q, overflow_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   a_slice_c;
   logic [WIDTH-1:0]   b_slice_c;
   logic [WIDTH:0]     slice_sum_c;
   logic               slice_ovf_c;

   // Shared slice datapath; B is inverted for subtract, carry-in comes from the chain register
   always_comb begin
      a_slice_c   = a_q[idx_q*WIDTH +: WIDTH];
      b_slice_c   = b_q[idx_q*WIDTH +: WIDTH] ^ {WIDTH{op_q}};
      slice_sum_c = {1'b0, a_slice_c} + {1'b0, b_slice_c} + (WIDTH+1)'(carry_q);
      // carry into MSB xor carry out of MSB, expressed via operand/result sign bits
      slice_ovf_c = (a_slice_c[WIDTH-1] == b_slice_c[WIDTH-1]) &&
                    (slice_sum_c[WIDTH-1] != a_slice_c[WIDTH-1]);
   end

   // Next-state and datapath update
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      carry_d      = carry_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      data_out_d   = data_out_q;
      carry_out_d  = carry_out_q;
      borrow_out_d = borrow_out_q;
      overflow_d   = overflow_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = data_in1;
               b_d     = data_in2;
               op_d    = control_signal;
               carry_d = control_signal;
               idx_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            data_out_d[idx_q*WIDTH +: WIDTH] = slice_sum_c[WIDTH-1:0];
            carry_d = slice_sum_c[WIDTH];
            if (idx_q == IDX_W'(WORDS - 1)) begin
               overflow_d   = slice_ovf_c;
               carry_out_d  = slice_sum_c[WIDTH] & ~op_q;
               borrow_out_d = ~slice_sum_c[WIDTH] & op_q;
               state_d      = DONE;
            end else begin
               idx_d = IDX_W'(idx_q + 1'b1);
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         carry_q      <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= 1'b0;
         data_out_q   <= '0;
         carry_out_q  <= 1'b0;
         borrow_out_q <= 1'b0;
         overflow_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         carry_q      <= carry_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         data_out_q   <= data_out_d;
         carry_out_q  <= carry_out_d;
         borrow_out_q <= borrow_out_d;
         overflow_q   <= overflow_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign data_out   = data_out_q;
   assign carry_out  = carry_out_q;
   assign borrow_out = borrow_out_q;
   assign overflow   = overflow_q;

endmodule

// File: doc/multiword_addsub_seq.md
Name: multiword_addsub_seq

Overview:
- Sequences one WIDTH-bit ripple add/sub slice over WORDS consecutive cycles to add or subtract two operands of WIDTH*WORDS bits.
- Processes one slice per cycle, least-significant first, and chains the carry between slices in a register.
- Sits between a requester (start/done handshake) and the shared narrow adder datapath.
- Trades latency for area on wide arithmetic.

Parameters:
- WIDTH, 8, bit width of the add/sub slice processed per cycle.
- WORDS, 4, number of slices per operation; the full operand width is WIDTH*WORDS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only while busy=0.
- control_signal  input  1  operation select: 0 = add, 1 = subtract (data_in1 - data_in2).
- data_in1  input  WIDTH*WORDS  operand A; captured on the accepting edge.
- data_in2  input  WIDTH*WORDS  operand B; captured on the accepting edge.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse; result outputs valid.
- data_out  output  WIDTH*WORDS  result; held until the next accepted start.
- carry_out  output  1  final carry for add; always 0 for subtract.
- borrow_out  output  1  inverted final carry for subtract; always 0 for add.
- overflow  output  1  signed overflow of the full-width operation.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE; slice index=0; carry register=0; busy=0, done=0, data_out=0, carry_out=0, borrow_out=0, overflow=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0. If start=1 at an edge:
  - latch A, B and op;
  - set the carry register to op (carry-in 1 for subtract);
  - set index=0;
  - go to RUN.
- RUN: busy=1. Each cycle the slice computes A[k] + (B[k] XOR {WIDTH{op}}) + carry, where k = index.
  - At the edge, write the sum into data_out[k*WIDTH +: WIDTH] and store the slice carry-out in the carry register.
  - If k = WORDS-1, go to DONE; otherwise increment index.
- Last slice (k = WORDS-1):
  - overflow <= carry into the slice MSB XOR carry out of the slice MSB;
  - carry_out <= final carry AND NOT op;
  - borrow_out <= (NOT final carry) AND op.
- DONE: done=1 for exactly this cycle; busy=0; unconditionally return to IDLE. A start sampled in DONE is accepted exactly as in IDLE, so back-to-back operations are allowed.
- Latency: start accepted at edge E0 -> slices written at edges E1..E_WORDS -> done high during the cycle after E_WORDS. For WORDS=4, done is high in cycle 5 after start.
- start while busy=1: ignored; latched operands and op are unaffected. The requester must re-assert start.
- Inputs may change freely after the accepting edge; only the latched copies are used.
- Output visibility:
  - data_out slices are updated progressively during RUN, so intermediate values are visible while busy=1. They are valid only when done=1 or in IDLE after a completed operation.
  - carry_out, borrow_out and overflow keep the previous operation's values until the last slice of the new operation.
- Reset mid-RUN: the operation is abandoned and all outputs clear; no done pulse is produced.
- Arithmetic is modulo 2^(WIDTH*WORDS); there is no saturation.
- WORDS=1 is legal: RUN lasts one cycle.

Test Plan:
- Add with full carry ripple: WIDTH=8, WORDS=4, A=0xFFFFFFFF, B=0x00000001, op=0, start 1 cycle -> busy high for 4 cycles; done in cycle 5; data_out=0x00000000, carry_out=1, borrow_out=0, overflow=0.
- Subtract with borrow: A=0x00000005, B=0x00000007, op=1 -> data_out=0xFFFFFFFE, borrow_out=1, carry_out=0, overflow=0. Then A=7, B=5 -> data_out=0x00000002, borrow_out=0.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001 add -> data_out=0x80000000, overflow=1, carry_out=0. Also A=0x80000000, B=0x00000001 subtract -> data_out=0x7FFFFFFF, overflow=1.
- Start during busy: start add 0x00000010+0x00000020; 2 cycles later pulse start with different operands -> second request ignored; data_out=0x00000030; exactly one done pulse.
- Back-to-back: hold start high with new operands in the done cycle -> second operation accepted; busy rises the next cycle; second done arrives 5 cycles after the first.
- Reset mid-operation: assert rst asynchronously during the 2nd RUN cycle -> busy, done, data_out, carry_out, borrow_out and overflow go to 0 immediately. After release, no done pulse appears until a new start.
